fifo_fwft: RTL
==============

FIFO_FWFT -- requirements
Module: fifo_fwft

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of data and q; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8: storage words; SHALL be a power of two >= 2.
REQ-003 Parameter ALMOST_MTY, default 1: almost_mty threshold in words.
REQ-004 Parameter ALMOST_FULL, default 1: almost_full threshold as free words remaining.
REQ-005 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Port clk, input, 1: sole clock, rising edge.
REQ-007 Port arst, input, 1: reset, asynchronous, active-high.
REQ-008 Port srst, input, 1: synchronous clear, active-high.
REQ-009 Port wr, input, 1: write request.
REQ-010 Port rd, input, 1: read request.
REQ-011 Port data, input, DATA_WIDTH: write data.
REQ-012 Port q, output, DATA_WIDTH: read data.
REQ-013 Port full / almost_full / mty / almost_mty, output, 1 each: status flags.
REQ-014 Port count, output, $clog2(DEPTH+1): stored-word occupancy.
REQ-015 Port overflow / underflow, output, 1 each: single-cycle error pulses.

Function
REQ-016 Write acceptance: wr=1 and full=0 at the clock edge; store data at the write pointer and advance it by 1 modulo DEPTH.
REQ-017 Read acceptance: rd=1 and mty=0 at the clock edge; advance the read pointer by 1 modulo DEPTH.
REQ-018 Acceptance decisions use the registered flag values before the edge.
REQ-019 Simultaneous accepted write and read leave count unchanged.
REQ-020 When full=1 and wr=rd=1, accept the read and reject the write.
REQ-021 When mty=1 and wr=rd=1, accept the write and reject the read.
REQ-022 count increments by 1 on write-only acceptance and decrements by 1 on read-only acceptance; range 0..DEPTH, no wrap.
REQ-023 All flags are registered from the next-state count, valid in the same cycle count updates:
 - full = (count==DEPTH)
 - mty = (count==0)
 - almost_full = (count >= DEPTH-ALMOST_FULL)
 - almost_mty = (count <= ALMOST_MTY)
REQ-024 Pointer wrap at DEPTH-1 -> 0 is seamless; data order is strictly first-in first-out across wrap.
REQ-025 FWFT=0: on an accepted read, q loads the oldest word at that edge (1-cycle latency); q otherwise holds its value.
REQ-026 FWFT=1, outputs while mty=0:
 - q continuously presents the oldest word.
 - An accepted read exposes the next word in the following cycle.
REQ-027 FWFT=1, write into an empty FIFO: the word is on q in the cycle after the write edge, coincident with mty deasserting.
REQ-028 FWFT=1 and mty=1: q value is don't-care.
REQ-029 overflow pulses high for exactly one cycle, the cycle after any edge where wr=1 and full=1.
REQ-030 underflow pulses high for exactly one cycle, the cycle after any edge where rd=1 and mty=1.
REQ-031 A rejected operation SHALL NOT alter pointers, count, memory, or q.
REQ-032 Storage words are not reset; reading them is only possible after they have been written.

Reset
REQ-033 arst=1 SHALL immediately force the following, overriding all other inputs:
 - pointers = 0, count = 0, q = 0
 - mty = 1, almost_mty = 1
 - full = 0, almost_full = 0
 - overflow = 0, underflow = 0
REQ-034 srst=1 at a clock edge SHALL produce the same state as arst; it has priority over wr/rd in that cycle, which are discarded.
REQ-035 Reset asserted mid-operation discards all stored words; after release the FIFO behaves as freshly empty.

Verification
REQ-036 DEPTH=8, FWFT=0: write 0x1..0x8, then read 8 -> q=0x1..0x8 in order, each one cycle after its read edge; full=1 at count=8; almost_full=1 at count=7; mty=1 after the last read.
REQ-037 Full FIFO (count=8), wr=1 with data 0x9 -> overflow high for one cycle; count stays 8; later reads return no 0x9.
REQ-038 Empty FIFO, rd=1 -> underflow high for one cycle; q unchanged; count=0.
REQ-039 count=8, wr=rd=1 -> read accepted, write rejected, count=7, overflow=1. count=0, wr=rd=1 -> count=1, underflow=1.
REQ-040 FWFT=1: write 0xA to an empty FIFO -> next cycle q=0xA and mty=0. Then 20 cycles of wr=rd=1 with incrementing data -> q sequence in order across pointer wrap, count=1 throughout.
REQ-041 Reset mid-operation, count=5:
 - Pulse arst between edges -> outputs at reset values immediately.
 - Repeat with srst=1 and wr=1 -> count=0, write discarded.

Source files
------------

// File: rtl/fifo_fwft_if.sv
// rtl/fifo_fwft_if.sv - Handshake and status bundle between a FIFO user and fifo_fwft.
interface fifo_fwft_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] q;
    logic                  full;
    logic                  almost_full;
    logic                  mty;
    logic                  almost_mty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd, data,
        input  q, full, almost_full, mty, almost_mty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd, data,
        output q, full, almost_full, mty, almost_mty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - Synchronous FIFO with registered-read or first-word-fall-through output.
module fifo_fwft #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 8,
    parameter int ALMOST_MTY  = 1,
    parameter int ALMOST_FULL = 1,
    parameter int FWFT        = 0
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          srst,
    fifo_fwft_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL  = CW'(DEPTH - ALMOST_FULL);
    localparam logic [CW-1:0] AE_LVL  = CW'(ALMOST_MTY);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_nx;
    logic [DATA_WIDTH-1:0] q_r;
    logic                  full_r;
    logic                  mty_r;
    logic                  afull_r;
    logic                  amty_r;
    logic                  ovf_r;
    logic                  udf_r;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance looks only at the registered flags, so a full FIFO still takes a read
    // while refusing a simultaneous write, and an empty one the reverse.
    always_comb begin
        wr_ok    = bus.wr & ~full_r;
        rd_ok    = bus.rd & ~mty_r;
        count_nx = count_r;
        if (wr_ok && !rd_ok) begin
            count_nx = count_r + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nx = count_r - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            q_r     <= '0;
            full_r  <= 1'b0;
            mty_r   <= 1'b1;
            afull_r <= 1'b0;
            amty_r  <= 1'b1;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else if (srst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            q_r     <= '0;
            full_r  <= 1'b0;
            mty_r   <= 1'b1;
            afull_r <= 1'b0;
            amty_r  <= 1'b1;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                q_r    <= mem[rd_ptr];
            end
            count_r <= count_nx;
            full_r  <= (count_nx == DEPTH_C);
            mty_r   <= (count_nx == '0);
            afull_r <= (count_nx >= AF_LVL);
            amty_r  <= (count_nx <= AE_LVL);
            ovf_r   <= bus.wr & full_r;
            udf_r   <= bus.rd & mty_r;
        end
    end

    // Storage has no reset; a reset edge must still not commit a pending write.
    always_ff @(posedge clk) begin
        if (wr_ok && !srst && !arst) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    // In fall-through mode the head word is shown directly; zero while empty keeps q at
    // its reset value during and right after reset.
    assign bus.q           = (FWFT != 0) ? (mty_r ? '0 : mem[rd_ptr]) : q_r;
    assign bus.count       = count_r;
    assign bus.full        = full_r;
    assign bus.mty         = mty_r;
    assign bus.almost_full = afull_r;
    assign bus.almost_mty  = amty_r;
    assign bus.overflow    = ovf_r;
    assign bus.underflow   = udf_r;
endmodule
